// File: rtl/clk_div_n_if.sv
// Control and status bundle for clk_div_n: run/load requests in, divided clock and status out.
interface clk_div_n_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             load;
    logic [CNT_W-1:0] div_val;
    logic             clk_div;
    logic             tick;
    logic             busy;
    logic             load_ack;
    logic             running;

    modport master (
        output en, load, div_val,
        input  clk_div, tick, busy, load_ack, running
    );

    modport slave (
        input  en, load, div_val,
        output clk_div, tick, busy, load_ack, running
    );
endinterface

// File: rtl/clk_div_n.sv
// Programmable integer clock divider with period-aligned start/stop and divisor reload.
// Define CLK_DIV_N_ODD50_EN to add a negedge stage giving 50% duty for odd divisors.
module clk_div_n #(
    parameter int CNT_W    = 8,
    parameter int DIV_INIT = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    clk_div_n_if.slave bus
);

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] DIV_RST = (DIV_INIT < 2) ? CNT_W'(2) : CNT_W'(DIV_INIT);

    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
        return (v < CNT_W'(2)) ? CNT_W'(2) : v;
    endfunction

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] div_reg, div_next;
    logic [CNT_W-1:0] pend_reg, pend_next;
    logic             clk_p_reg, clk_p_next;
    logic             tick_reg, tick_next;
    logic             busy_reg, busy_next;
    logic             ack_reg, ack_next;

    logic [CNT_W-1:0] last_cnt;
    logic [CNT_W-1:0] half_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             boundary;
    logic             clk_ext;

    assign last_cnt = div_reg - CNT_W'(1);
    assign half_cnt = div_reg >> 1;
    assign cnt_inc  = cnt_reg + CNT_W'(1);
    // A boundary is either the start request while stopped or the wrap of a running period.
    assign boundary = (state_reg == STOP) ? bus.en : (cnt_reg == last_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= STOP;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (boundary) begin
            state_next = bus.en ? RUN : STOP;
        end
    end

    always_comb begin
        cnt_next   = cnt_reg;
        clk_p_next = clk_p_reg;
        tick_next  = 1'b0;
        ack_next   = 1'b0;
        busy_next  = busy_reg;
        div_next   = div_reg;
        pend_next  = pend_reg;

        if (boundary) begin
            cnt_next = '0;
            if (bus.en) begin
                clk_p_next = 1'b1;
                tick_next  = 1'b1;
                if (busy_reg) begin
                    div_next  = pend_reg;
                    busy_next = 1'b0;
                    ack_next  = 1'b1;
                end
            end else begin
                clk_p_next = 1'b0;
            end
        end else if (state_reg == RUN) begin
            cnt_next   = cnt_inc;
            clk_p_next = (cnt_inc < half_cnt);
        end

        // A load on a boundary edge is applied after the commit above, so it waits one period.
        if (bus.load) begin
            pend_next = clamp_div(bus.div_val);
            busy_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            clk_p_reg <= 1'b0;
            tick_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            ack_reg   <= 1'b0;
            div_reg   <= DIV_RST;
            pend_reg  <= DIV_RST;
        end else begin
            cnt_reg   <= cnt_next;
            clk_p_reg <= clk_p_next;
            tick_reg  <= tick_next;
            busy_reg  <= busy_next;
            ack_reg   <= ack_next;
            div_reg   <= div_next;
            pend_reg  <= pend_next;
        end
    end

`ifdef CLK_DIV_N_ODD50_EN
    logic clk_n_reg;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_n_reg <= 1'b0;
        end else begin
            clk_n_reg <= clk_p_reg;
        end
    end

    // clk_n_reg is low whenever div_reg can change (end of a period), so the mask never glitches.
    assign clk_ext = clk_n_reg & div_reg[0];
`else
    assign clk_ext = 1'b0;
`endif

    always_comb begin
        bus.clk_div  = clk_p_reg | clk_ext;
        bus.running  = (state_reg == RUN);
        bus.tick     = tick_reg;
        bus.busy     = busy_reg;
        bus.load_ack = ack_reg;
    end

endmodule

// File: doc/clk_div_n.md
CLK_DIV_N -- requirements
Module: clk_div_n

Interface
REQ-001 SHALL provide parameter CNT_W, default 8, width of divisor and counter.
REQ-002 SHALL provide parameter DIV_INIT, default 5, divisor loaded at reset.
REQ-003 SHALL have port clk  input  1  single block clock; all logic in this domain.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  run request; level-sensitive.
REQ-006 SHALL have port load  input  1  one-cycle request to capture div_val.
REQ-007 SHALL have port div_val  input  CNT_W  requested divisor N.
REQ-008 SHALL have port clk_div  output  1  divided clock.
REQ-009 SHALL have port tick  output  1  one-cycle pulse at each period start.
REQ-010 SHALL have port busy  output  1  high while a captured divisor is pending.
REQ-011 SHALL have port load_ack  output  1  one-cycle pulse when the pending divisor becomes active.
REQ-012 SHALL have port running  output  1  high while periods are being generated.

Function
REQ-013 Counter cnt SHALL count 0..N-1 on rising clk edges, where N is the active divisor div_q; the wrap from N-1 to 0 is a period boundary.
REQ-014 Divisor values 0 and 1 SHALL be clamped to 2 on capture.
REQ-015 States SHALL be STOP and RUN; STOP->RUN on the first rising edge with en=1 (the boundary edge): cnt<=0, clk_p<=1, tick<=1.
REQ-016 In RUN, the posedge register clk_p SHALL be high while cnt < H, where H = floor(N/2), and low otherwise.
REQ-017 Even N SHALL give clk_div = clk_p: high N/2 cycles, low N/2 cycles.
REQ-018 The block SHALL not apply en=0 mid-period; at the boundary with en=0, RUN->STOP: cnt held 0, clk_p<=0, no tick, running<=0.
REQ-019 clk_div SHALL never glitch; it SHALL only change on clk edges and SHALL not produce a truncated period on start, stop or divisor change.
REQ-020 load=1 SHALL write div_val, clamped, into the pending register and set busy on that edge; a repeated load while busy SHALL overwrite the pending value, last wins.
REQ-021 A pending value SHALL become div_q at the next boundary, including STOP->RUN; at that edge busy<=0 and load_ack<=1, coincident with tick.
REQ-022 load sampled on a boundary edge SHALL go to the pending register and SHALL take effect at the following boundary.
REQ-023 tick and load_ack SHALL each be exactly one clk cycle wide.

Reset
REQ-024 rst_n=0 SHALL immediately force: state STOP, cnt=0, clk_p=0, negedge register clk_n=0, clk_div=0, tick=0, busy=0, load_ack=0, running=0, div_q=DIV_INIT (clamped).
REQ-025 Reset mid-period SHALL discard the pending divisor; after release, operation SHALL resume only via REQ-015.

Configuration
REQ-026 Macro CLK_DIV_N_ODD50_EN SHALL control odd-N duty correction.
REQ-027 With the macro defined, a negedge register clk_n SHALL capture clk_p, and odd N SHALL give clk_div = clk_p | clk_n: high N/2 cycles (x.5), low N/2 cycles.
REQ-028 Without the macro, clk_n SHALL not exist, and clk_div = clk_p for all N: odd N high (N-1)/2 cycles, low (N+1)/2 cycles.
REQ-029 Even-N behaviour SHALL be identical with and without the macro.

Verification
REQ-030 Reset, en=1, N=4 -> clk_div 2 high / 2 low, tick every 4 cycles, first tick on the first edge with en=1.
REQ-031 With the macro, N=5 -> high 2.5 / low 2.5 cycles, measured between clk_div edges; without the macro -> high 2 / low 3.
REQ-032 N=4 running, load with div_val=7 at cnt=1 -> busy=1; current period completes 4 cycles; at boundary load_ack=tick=1, busy=0; next periods 7 cycles (3/4, or 3.5/3.5 with the macro).
REQ-033 en dropped at cnt=1 of N=6 -> period completes full 6 cycles, then clk_div stays 0, running=0, no further tick; en=1 again restarts with a tick.
REQ-034 load div_val=0 and div_val=1 -> active N=2, clk_div toggles every cycle.
REQ-035 rst_n pulsed low at cnt=3 of N=8 with a load pending -> all outputs 0 immediately, busy=0, div_q=DIV_INIT after release.
